sqrt_inv_u16: RTL and testbench

Inverse companion to `sqrt_u32`. It takes an unsigned root `q` and remainder `r` and reconstructs the radicand `x = q*q + r` with a sequential shift-add multiplier. It also flags remainders that no integer square root could have produced (`r > 2q`). It sits on the verification/reconstruction side of the square-root datapath and closes the loop on root/remainder pairs. It is a multi-cycle unit: one operation in flight, valid/ready on input, single-cycle valid pulse on output.

---
 rtl/sqrt_inv_u16.sv | 88 ++++++++
 tb/tb_sqrt_inv_u16.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt_inv_u16.sv
// Radicand reconstruction x = q*q + r using a sequential shift-add multiplier.
// Also flags remainders larger than 2q, which no integer square root could leave.
module sqrt_inv_u16 #(
    parameter int Q_WIDTH    = 16,
    parameter int R_WIDTH    = Q_WIDTH + 1,
    parameter int DATA_WIDTH = 2 * Q_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_o,
    input  logic [Q_WIDTH-1:0]    q_i,
    input  logic [R_WIDTH-1:0]    r_i,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o
);
    localparam int CW = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] mcand;
    logic [Q_WIDTH-1:0]    mplier;
    logic [DATA_WIDTH:0]   acc;
    logic [DATA_WIDTH:0]   acc_sum;
    logic [CW-1:0]         cnt;
    logic                  err_flag;
    logic [R_WIDTH-1:0]    q_dbl;
    logic                  last_step;

    assign ready_o   = (state == IDLE);
    assign q_dbl     = R_WIDTH'({q_i, 1'b0});
    assign last_step = (cnt == CW'(Q_WIDTH - 1));
    assign acc_sum   = mplier[0] ? acc + {1'b0, mcand} : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (valid_in) state_nx = MUL;
            MUL:     if (last_step) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Remainder preloads the accumulator, so the final sum needs no extra add step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            err_flag  <= 1'b0;
            valid_out <= 1'b0;
            data_o    <= '0;
            err_o     <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: if (valid_in) begin
                    mcand    <= DATA_WIDTH'(q_i);
                    mplier   <= q_i;
                    acc      <= (DATA_WIDTH + 1)'(r_i);
                    cnt      <= '0;
                    err_flag <= (r_i > q_dbl);
                end
                MUL: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        data_o    <= acc_sum[DATA_WIDTH-1:0];
                        err_o     <= err_flag;
                        valid_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_inv_u16.sv
// Bench for sqrt_inv_u16: queue-based reference model checked every cycle,
// plus directed vectors with literal expected values.
module tb_sqrt_inv_u16;
    localparam int QW = 16;
    localparam int RW = 17;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_o;
    logic [QW-1:0] q_i = '0;
    logic [RW-1:0] r_i = '0;
    logic          valid_out;
    logic [DW-1:0] data_o;
    logic          err_o;

    sqrt_inv_u16 dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_o(ready_o),
        .q_i(q_i), .r_i(r_i), .valid_out(valid_out), .data_o(data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic longint model_data(input longint q, input longint r);
        return (q * q + r) & 64'hFFFF_FFFF;
    endfunction

    function automatic longint model_err(input longint q, input longint r);
        return (r > 2 * q) ? 1 : 0;
    endfunction

    function automatic longint isqrt(input longint x);
        longint lo, hi, mid;
        lo = 0; hi = 65536;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    typedef struct {longint t; longint q; longint r;} op_t;
    op_t    pend[$];
    longint cyc = 0;
    longint busy_until = 0;
    longint last_data = 0;
    longint last_err = 0;
    int     pulses = 0;

    // Accept model: the unit takes a new operation whenever it is not busy.
    always @(posedge clk) begin
        op_t o;
        if (!rst && valid_in && cyc >= busy_until) begin
            o.t = cyc; o.q = q_i; o.r = r_i;
            pend.push_back(o);
            busy_until = cyc + 18;
        end
        cyc++;
    end

    always @(negedge clk) begin
        op_t    o;
        longint ed, ee;
        if (valid_out) pulses++;
        if (rst) begin
            pend.delete();
            busy_until = 0;
            last_data = 0;
            last_err = 0;
            chk("rst_valid", valid_out, 0);
            chk("rst_data", data_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_ready", ready_o, 1);
        end else begin
            chk("ready", ready_o, (cyc >= busy_until) ? 1 : 0);
            if (pend.size() > 0 && pend[0].t + 17 == cyc) begin
                o = pend.pop_front();
                ed = model_data(o.q, o.r);
                ee = model_err(o.q, o.r);
                chk("valid_out", valid_out, 1);
                chk("data", data_o, ed);
                chk("err", err_o, ee);
                if (ee == 0) chk("root_back", isqrt(longint'(data_o)), o.q);
                last_data = ed;
                last_err = ee;
            end else begin
                chk("valid_idle", valid_out, 0);
                chk("data_hold", data_o, last_data);
                chk("err_hold", err_o, last_err);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (!ready_o && k < 100) begin @(negedge clk); k++; end
        if (!ready_o) chk("idle_timeout", 0, 1);
    endtask

    task automatic run_op(input string name, input longint q, input longint r,
                          input longint exp_d, input longint exp_e);
        int k;
        wait_idle();
        @(posedge clk); #1;
        valid_in = 1'b1; q_i = QW'(q); r_i = RW'(r);
        @(posedge clk); #1;
        valid_in = 1'b0; q_i = $urandom; r_i = $urandom;
        k = 0;
        do begin @(negedge clk); k++; end while (!valid_out && k < 40);
        chk({name, "_lat"}, k - 1, 16);
        chk({name, "_data"}, data_o, exp_d);
        chk({name, "_err"}, err_o, exp_e);
        @(negedge clk);
        chk({name, "_pulse"}, valid_out, 0);
    endtask

    task automatic drive_stream(input int cycles, input bit bad);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1;
            q_i = QW'($urandom);
            if (bad) r_i = RW'($urandom_range(131071, 2 * int'(q_i) + 1));
            else     r_i = RW'($urandom_range(2 * int'(q_i), 0));
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    initial begin
        int p0;
        chk("pin_model_a", model_data(46340, 88048), 64'd2147483648);
        chk("pin_model_b", model_data(65535, 131071), 0);
        chk("pin_model_err", model_err(3, 7), 1);
        chk("pin_isqrt", isqrt(64'd4294967295), 65535);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op("basic",  16, 0, 256, 0);
        run_op("q15r30", 15, 30, 255, 0);
        run_op("q3r7",   3, 7, 16, 1);
        run_op("zero",   0, 0, 0, 0);
        run_op("q0r1",   0, 1, 1, 1);
        run_op("large",  46340, 88048, 64'd2147483648, 0);
        run_op("maxok",  65535, 131070, 64'd4294967295, 0);
        run_op("wrap",   65535, 131071, 0, 1);

        // Held valid_in with operands changing every cycle: one accept per 18 cycles.
        wait_idle();
        p0 = pulses;
        drive_stream(72, 1'b0);
        repeat (20) @(posedge clk);
        chk("b2b_pulses", pulses - p0, 4);

        // Reset five cycles into an operation.
        wait_idle();
        @(posedge clk); #1;
        valid_in = 1'b1; q_i = 16'd1000; r_i = '0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_data", data_o, 0);
        chk("midrst_valid", valid_out, 0);
        chk("midrst_ready", ready_o, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        p0 = pulses;
        repeat (20) @(posedge clk);
        chk("midrst_no_pulse", pulses - p0, 0);
        run_op("after_rst", 1000, 0, 1000000, 0);

        wait_idle();
        drive_stream(300 * 18, 1'b0);
        drive_stream(60 * 18, 1'b1);
        repeat (25) @(posedge clk);
        chk("queue_drained", pend.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
